sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO. It is the same-domain successor of the bridge CDC FIFOs and is used inside AXI slave wrappers and the FPU result queue, where both sides share the clock.
- Adds features the CDC FIFOs lack: configurable width/depth, occupancy count, programmable almost-full/almost-empty, first-word-fall-through (FWFT) mode, synchronous flush, sticky overflow/underflow error flags.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/sync_fifo_param_if.sv | 37 +++
 rtl/sync_fifo_mem.sv | 28 ++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
// The status struct lets status registers capture every flag in one word.
package fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
    logic ovf;
    logic udf;
  } fifo_status_t;

  // Never returns 0, so an index field is always at least one bit wide.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Push/pop/status bundle between a FIFO user (master) and sync_fifo_param (slave).
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CW = clog2_safe(DEPTH) + 1;

  // Handshake: push is taken at an edge when !full, or when a pop is taken
  // at that same edge; pop is taken when !empty; rvalid qualifies rdata.
  logic              flush;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              afull;
  logic              aempty;
  logic [CW-1:0]     count;
  logic              ovf;
  logic              udf;

  modport master (
    output flush, push, pop, wdata,
    input  rdata, rvalid, full, empty, afull, aempty, count, ovf, udf
  );

  modport slave (
    input  flush, push, pop, wdata,
    output rdata, rvalid, full, empty, afull, aempty, count, ovf, udf
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: register array with one write port and an asynchronous read port.
// Kept separate so it can be replaced by an SRAM macro; contents are not reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int AW     = clog2_safe(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy, almost-full/empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 0
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = clog2_safe(DEPTH);
  localparam logic [AW:0] AF_TH = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_TH = (AW+1)'(AEMPTY_TH);

  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic [DATA_W-1:0] rdata_q, rdata_d, mem_rdata;
  logic              rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic              push_ok, pop_ok, mem_we;
  fifo_status_t      status;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wptr_q - rptr_q;

  always_comb begin
    status        = '0;
    status.empty  = (wptr_q == rptr_q);
    status.full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    status.afull  = (count >= AF_TH);
    status.aempty = (count <= AE_TH);
    status.ovf    = ovf_q;
    status.udf    = udf_q;
  end

  // A pop at the same edge frees the slot a push into a full FIFO needs.
  assign pop_ok  = bus.pop & ~status.empty;
  assign push_ok = bus.push & (~status.full | pop_ok);
  assign mem_we  = push_ok & ~bus.flush;

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (bus.wdata),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (bus.flush) begin
      wptr_d = '0;
      rptr_d = '0;
      ovf_d  = 1'b0;
      udf_d  = 1'b0;
    end else begin
      wptr_d   = wptr_q + (AW+1)'(push_ok);
      rptr_d   = rptr_q + (AW+1)'(pop_ok);
      rvalid_d = pop_ok;
      if (pop_ok) begin
        rdata_d = mem_rdata;
      end
      if (bus.push && !push_ok) begin
        ovf_d = 1'b1;
      end
      if (bus.pop && !pop_ok) begin
        udf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // In FWFT mode the head entry is shown straight from the array.
  assign bus.rdata  = (FWFT != 0) ? mem_rdata : rdata_q;
  assign bus.rvalid = (FWFT != 0) ? ~status.empty : rvalid_q;
  assign bus.full   = status.full;
  assign bus.empty  = status.empty;
  assign bus.afull  = status.afull;
  assign bus.aempty = status.aempty;
  assign bus.count  = count;
  assign bus.ovf    = status.ovf;
  assign bus.udf    = status.udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Drives a standard-read and an FWFT instance with identical stimulus and checks
// both against a queue-based model of the FIFO's externally visible behaviour.
module tb_sync_fifo_param;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int AFULL_TH  = 6;
  localparam int AEMPTY_TH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus0 ();
  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus1 ();

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(0)
  ) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH), .FWFT(1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic              ovf_m, udf_m, rv0_m;
  logic [DATA_W-1:0] rd0_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic f, input logic p, input logic q, input logic [31:0] w);
    bus0.flush = f;  bus0.push = p;  bus0.pop = q;  bus0.wdata = w;
    bus1.flush = f;  bus1.push = p;  bus1.pop = q;  bus1.wdata = w;
  endtask

  task automatic model_reset();
    exp_q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    rv0_m = 1'b0;
    rd0_m = '0;
  endtask

  // One clock edge of FIFO behaviour, computed from the occupancy before the edge.
  task automatic model_update(input logic f, input logic p, input logic q, input logic [31:0] w);
    bit pop_ok, push_ok;
    if (f) begin
      exp_q.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
      rv0_m = 1'b0;
    end else begin
      pop_ok  = q && (exp_q.size() > 0);
      push_ok = p && ((exp_q.size() < DEPTH) || pop_ok);
      if (p && !push_ok) ovf_m = 1'b1;
      if (q && !pop_ok)  udf_m = 1'b1;
      rv0_m = pop_ok;
      if (pop_ok)  rd0_m = exp_q.pop_front();
      if (push_ok) exp_q.push_back(w);
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    chk("count0",  32'(bus0.count),  n);
    chk("count1",  32'(bus1.count),  n);
    chk("full0",   32'(bus0.full),   32'(n == DEPTH));
    chk("full1",   32'(bus1.full),   32'(n == DEPTH));
    chk("empty0",  32'(bus0.empty),  32'(n == 0));
    chk("empty1",  32'(bus1.empty),  32'(n == 0));
    chk("afull0",  32'(bus0.afull),  32'(n >= AFULL_TH));
    chk("afull1",  32'(bus1.afull),  32'(n >= AFULL_TH));
    chk("aempty0", 32'(bus0.aempty), 32'(n <= AEMPTY_TH));
    chk("aempty1", 32'(bus1.aempty), 32'(n <= AEMPTY_TH));
    chk("ovf0",    32'(bus0.ovf),    32'(ovf_m));
    chk("ovf1",    32'(bus1.ovf),    32'(ovf_m));
    chk("udf0",    32'(bus0.udf),    32'(udf_m));
    chk("udf1",    32'(bus1.udf),    32'(udf_m));
    chk("rvalid0", 32'(bus0.rvalid), 32'(rv0_m));
    chk("rdata0",  bus0.rdata,       rd0_m);
    chk("rvalid1", 32'(bus1.rvalid), 32'(n != 0));
    if (n != 0) chk("rdata1", bus1.rdata, exp_q[0]);
  endtask

  task automatic step(input logic f, input logic p, input logic q, input logic [31:0] w);
    drive(f, p, q, w);
    @(posedge clk);
    model_update(f, p, q, w);
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();

    // Reset state while rst_n is held low.
    rst_n = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with A0..A7, then push 0xFF into the full FIFO twice-checked for stickiness.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 32'hA0 + 32'(i));
    step(1'b0, 1'b1, 1'b0, 32'hFF);
    step(1'b0, 1'b0, 1'b0, '0);

    // Push and pop together while full, then drain everything.
    step(1'b0, 1'b1, 1'b1, 32'hB8);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, '0);

    // Push and pop together while empty: pop rejected, word appears next cycle.
    step(1'b0, 1'b1, 1'b1, 32'hC0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Steady occupancy of 3 across several pointer wraps.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, $urandom);

    // Flush at count 5 with ovf set; concurrent push/pop must be ignored.
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, $urandom);
    step(1'b0, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 1'b1, $urandom);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 31) == 0),
           ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 99) < 50),
           $urandom);
    end

    // Asynchronous reset in the middle of a burst, checked before any edge.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, ($urandom_range(0, 1) == 1), $urandom);
    drive(1'b0, 1'b1, 1'b0, $urandom);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    drive(1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0, 32'hD00D_0001);
    step(1'b0, 1'b1, 1'b1, 32'hD00D_0002);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
